// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive controller: register map,
// STATUS bit positions, ack handshake states and the reset baud divisor.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV_LO = 2'd2;
  localparam logic [1:0] ADDR_DIV_HI = 2'd3;

  localparam int ST_IRQ_EN  = 0;
  localparam int ST_NEMPTY  = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVERRUN = 3;

  // 50 MHz / 115200 baud
  localparam logic [11:0] DEFAULT_DIV = 12'd434;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DRAIN
  } ack_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO. A pop on empty is ignored; a push on full only
// lands when a pop in the same cycle frees the head slot.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: acks the receiver core, buffers bytes in a FIFO and
// exposes data/status/divisor registers. Define UART_RX_IRQ_EN to add the irq output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH  = 8,
  parameter int               DIV_W       = 12,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             rx_clr_rdy,
  output logic [DIV_W-1:0] baud_goal,
  input  logic             cs,
  input  logic             wr,
  input  logic             rd,
  input  logic [1:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             rd_valid
`ifdef UART_RX_IRQ_EN
  ,
  output logic             irq
`endif
);

  ack_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       div_lo_q, div_lo_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       status;
  logic             rd_acc, wr_acc;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
`ifdef UART_RX_IRQ_EN
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
`endif

  assign rd_acc     = cs & rd;
  assign wr_acc     = cs & wr;
  assign rx_clr_rdy = (state_q == ACK);
  assign baud_goal  = div_q;
  assign rdata      = rdata_q;
  assign rd_valid   = rd_valid_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // DRAIN holds off until rdy drops so a lingering rdy never pushes twice.
  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          fifo_push = 1'b1;
          state_d   = ACK;
        end
      end
      ACK:     state_d = DRAIN;
      DRAIN:   if (!rx_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status              = 8'h00;
    status[ST_NEMPTY]   = ~fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_OVERRUN]  = overrun_q;
`ifdef UART_RX_IRQ_EN
    status[ST_IRQ_EN]   = irq_en_q;
`endif
  end

  always_comb begin
    div_d      = div_q;
    div_lo_d   = div_lo_q;
    overrun_d  = overrun_q;
    rdata_d    = 8'h00;
    rd_valid_d = rd_acc;
    fifo_pop   = 1'b0;
`ifdef UART_RX_IRQ_EN
    irq_en_d   = irq_en_q;
`endif
    if (wr_acc) begin
      case (addr)
        ADDR_DIV_LO: div_lo_d = wdata;
        ADDR_DIV_HI: div_d    = {wdata[DIV_W-9:0], div_lo_q};
`ifdef UART_RX_IRQ_EN
        ADDR_STATUS: irq_en_d = wdata[0];
`endif
        default: ;
      endcase
    end
    if (rd_acc) begin
      case (addr)
        ADDR_DATA: begin
          fifo_pop = 1'b1;
          rdata_d  = fifo_empty ? 8'h00 : fifo_dout;
        end
        ADDR_STATUS: begin
          rdata_d   = status;
          overrun_d = 1'b0;
        end
        default: ;
      endcase
    end
    // A fresh drop wins over a same-cycle clear so the event is never lost.
    if (fifo_push && fifo_full && !fifo_pop) overrun_d = 1'b1;
  end

`ifdef UART_RX_IRQ_EN
  assign irq_d = irq_en_q & (~fifo_empty | overrun_q);
  assign irq   = irq_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= DEFAULT_DIV;
      div_lo_q   <= 8'h00;
      overrun_q  <= 1'b0;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
`ifdef UART_RX_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_lo_q   <= div_lo_d;
      overrun_q  <= overrun_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
`ifdef UART_RX_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: reads queue their expected byte and due
// cycle; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_clr_rdy;
  logic [11:0] baud_goal;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        rd_valid;
`ifdef UART_RX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_clr_rdy (rx_clr_rdy),
    .baud_goal  (baud_goal),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rd_valid   (rd_valid)
`ifdef UART_RX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", {24'h0, rdata}, {24'h0, e.data});
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [7:0] e);
    exp_t x;
    x.data = e;
    x.due  = cyc + 1;
    exp_q.push_back(x);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  // Core model: rdy held for at least 'hold' cycles and until clr is seen.
  task automatic core_send(input logic [7:0] b, input int hold);
    int n;
    int clr;
    int first;
    n = 0; clr = 0; first = 0;
    rx_rdy = 1'b1; rx_data = b;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rx_clr_rdy === 1'b1) begin
        clr++;
        if (first == 0) first = n;
      end
      if (clr > 0 && n >= hold) break;
    end
    rx_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rx_clr_rdy === 1'b1) clr++;
    end
    chk("clr_pulse_count", 32'(clr), 32'd1);
    chk("clr_pulse_delay", 32'(first), 32'd1);
  endtask

  // Byte arrives on the same cycle as a DATA read.
  task automatic simul(input logic [7:0] b, input logic [7:0] e);
    exp_t x;
    x.data = e;
    x.due  = cyc + 1;
    exp_q.push_back(x);
    rx_rdy = 1'b1; rx_data = b;
    cs = 1'b1; rd = 1'b1; addr = ADDR_DATA;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    chk("simul_clr", {31'h0, rx_clr_rdy}, 32'd1);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdata", {24'h0, rdata}, 32'h0);
    chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("reset_clr", {31'h0, rx_clr_rdy}, 32'h0);
    chk("reset_baud", {20'h0, baud_goal}, 32'd434);
    do_read(ADDR_STATUS, 8'h00);

    do_write(ADDR_DIV_LO, 8'h1B);
    chk("baud_after_lo", {20'h0, baud_goal}, 32'd434);
    do_write(ADDR_DIV_HI, 8'h01);
    chk("baud_after_hi", {20'h0, baud_goal}, 32'h11B);
    do_write(ADDR_DATA, 8'hFF);
    chk("baud_ignored_wr", {20'h0, baud_goal}, 32'h11B);
    do_read(ADDR_DIV_HI, 8'h00);
    do_read(ADDR_DIV_LO, 8'h00);

    core_send(8'hA5, 3);
    do_read(ADDR_DATA, 8'hA5);
    do_read(ADDR_STATUS, 8'h00);

    for (int i = 1; i <= 9; i++) core_send(8'(i), 1);
    do_read(ADDR_STATUS, 8'h0E);
    do_read(ADDR_STATUS, 8'h06);
    for (int i = 1; i <= 8; i++) do_read(ADDR_DATA, 8'(i));
    do_read(ADDR_STATUS, 8'h00);
    do_read(ADDR_DATA, 8'h00);

    simul(8'h77, 8'h00);
    do_read(ADDR_DATA, 8'h77);

    for (int i = 0; i < 8; i++) core_send(8'(8'h10 + i), 1);
    simul(8'h55, 8'h10);
    do_read(ADDR_STATUS, 8'h06);
    for (int i = 1; i < 8; i++) do_read(ADDR_DATA, 8'(8'h10 + i));
    do_read(ADDR_DATA, 8'h55);
    do_read(ADDR_STATUS, 8'h00);

    core_send(8'h99, 1);
    rx_rdy = 1'b1; rx_data = 8'hAA;
    @(negedge clk);
    chk("pre_reset_clr", {31'h0, rx_clr_rdy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_rdy = 1'b0;
    chk("midreset_clr", {31'h0, rx_clr_rdy}, 32'h0);
    chk("midreset_baud", {20'h0, baud_goal}, 32'd434);
    chk("midreset_rdata", {24'h0, rdata}, 32'h0);
    do_read(ADDR_STATUS, 8'h00);

`ifdef UART_RX_IRQ_EN
    do_write(ADDR_STATUS, 8'h01);
    do_read(ADDR_STATUS, 8'h01);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    rx_rdy = 1'b1; rx_data = 8'h3C;
    @(negedge clk);
    chk("irq_push_cycle", {31'h0, irq}, 32'h0);
    rx_rdy = 1'b0;
    @(negedge clk);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    @(negedge clk);
    do_read(ADDR_DATA, 8'h3C);
    chk("irq_pop_cycle", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'h0, irq}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("outstanding_reads", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
